// File: rtl/bit_slicer.sv
// Adaptive-threshold slicer with transition-based bit timing recovery.
// Emits one registered mid-bit decision (value, strobe, raw sample) per bit while locked.
module bit_slicer #(
  parameter int SPB       = 8,
  parameter int AVG_SH    = 6,
  parameter int TOL       = 1,
  parameter int ACQ_EDGES = 4,
  parameter int MAX_RUN   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       den,
  output logic [7:0] sout,
  output logic       bout,
  output logic       bvalid,
  output logic       locked,
  output logic [7:0] thr
);

  localparam int PW = $clog2(SPB);
  localparam int AW = 8 + AVG_SH;

  typedef enum logic {ACQ, LOCK} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] acc_q, acc_d;
  logic          s_prev_q, s_prev_d;
  logic [PW-1:0] ph_q, ph_d;
  logic [7:0]    ivl_q, ivl_d;
  logic [7:0]    run_q, run_d;
  logic [7:0]    gcnt_q, gcnt_d;
  logic [7:0]    sout_q, sout_d;
  logic          bout_q, bout_d;
  logic          bvalid_q, bvalid_d;

  logic          s_w, edge_w, mid_w, good_w;
  logic [8:0]    n_w;
  logic [PW-1:0] nmod_w;
  logic [7:0]    thr_w;

  assign thr_w  = acc_q[AVG_SH+7:AVG_SH];
  assign s_w    = (din > thr_w);
  assign edge_w = den && (s_w != s_prev_q);
  assign mid_w  = den && (ph_q == PW'(SPB/2));
  // SPB is a power of two, so the low bits of n are n mod SPB
  assign n_w    = {1'b0, ivl_q} + 9'd1;
  assign nmod_w = n_w[PW-1:0];
  assign good_w = (n_w >= 9'(SPB-TOL)) &&
                  ((nmod_w <= PW'(TOL)) || (nmod_w >= PW'(SPB-TOL)));

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    s_prev_d = s_prev_q;
    ph_d     = ph_q;
    ivl_d    = ivl_q;
    run_d    = run_q;
    gcnt_d   = gcnt_q;
    sout_d   = sout_q;
    bout_d   = bout_q;
    bvalid_d = 1'b0;
    if (den) begin
      acc_d    = acc_q + AW'(din) - (acc_q >> AVG_SH);
      s_prev_d = s_w;
      ivl_d    = edge_w ? '0 : ((ivl_q == '1) ? ivl_q : ivl_q + 8'd1);
      ph_d     = edge_w ? PW'(1) : ph_q + PW'(1);
      if (edge_w)
        run_d = '0;
      else if (mid_w && (run_q != '1))
        run_d = run_q + 8'd1;

      if (state_q == ACQ) begin
        if (edge_w) begin
          if (!good_w)
            gcnt_d = '0;
          else if (gcnt_q + 8'd1 == 8'(ACQ_EDGES)) begin
            state_d = LOCK;
            gcnt_d  = '0;
          end else
            gcnt_d = gcnt_q + 8'd1;
        end
      end else if (mid_w && ({1'b0, run_q} + 9'd1 == 9'(MAX_RUN))) begin
        state_d = ACQ;
        gcnt_d  = '0;
      end

      if (mid_w && (state_q == LOCK)) begin
        bvalid_d = 1'b1;
        bout_d   = s_w;
        sout_d   = din;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ACQ;
      acc_q    <= AW'(128) << AVG_SH;
      s_prev_q <= 1'b0;
      ph_q     <= '0;
      ivl_q    <= '0;
      run_q    <= '0;
      gcnt_q   <= '0;
      sout_q   <= '0;
      bout_q   <= 1'b0;
      bvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      s_prev_q <= s_prev_d;
      ph_q     <= ph_d;
      ivl_q    <= ivl_d;
      run_q    <= run_d;
      gcnt_q   <= gcnt_d;
      sout_q   <= sout_d;
      bout_q   <= bout_d;
      bvalid_q <= bvalid_d;
    end
  end

  assign sout   = sout_q;
  assign bout   = bout_q;
  assign bvalid = bvalid_q;
  assign locked = (state_q == LOCK);
  assign thr    = thr_w;

endmodule

// File: tb/tb_bit_slicer.sv
// Bench for bit_slicer: per-sample behavioural model checked every cycle,
// plus hand-derived lock timing and strobe counts for the directed scenarios.
module tb_bit_slicer;
  localparam int SPB       = 8;
  localparam int AVG_SH    = 6;
  localparam int TOL       = 1;
  localparam int ACQ_EDGES = 4;
  localparam int MAX_RUN   = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       den;
  logic [7:0] sout;
  logic       bout;
  logic       bvalid;
  logic       locked;
  logic [7:0] thr;

  always #5 clk = ~clk;

  bit_slicer #(
    .SPB(SPB), .AVG_SH(AVG_SH), .TOL(TOL), .ACQ_EDGES(ACQ_EDGES), .MAX_RUN(MAX_RUN)
  ) dut (
    .clk(clk), .rst(rst), .din(din), .den(den),
    .sout(sout), .bout(bout), .bvalid(bvalid), .locked(locked), .thr(thr)
  );

  int checks   = 0;
  int failures = 0;
  int bv_cnt   = 0;
  int prev_thr = 128;
  bit chk_en    = 0;
  bit mono_chk  = 0;
  bit lock_hold = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Reference model: one update per accepted sample, plain integer arithmetic.
  int m_acc, m_sprev, m_ph, m_ivl, m_run, m_gcnt, m_lock, m_bvalid, m_bout, m_sout;

  always @(posedge clk) begin : model
    int t, s, n, r;
    bit e, mid, good;
    if (rst) begin
      m_acc = 128 << AVG_SH; m_sprev = 0; m_ph = 0; m_ivl = 0; m_run = 0;
      m_gcnt = 0; m_lock = 0; m_bvalid = 0; m_bout = 0; m_sout = 0;
    end else if (!den) begin
      m_bvalid = 0;
    end else begin
      t    = m_acc >> AVG_SH;
      s    = (int'(din) > t) ? 1 : 0;
      e    = (s != m_sprev);
      n    = m_ivl + 1;
      r    = n % SPB;
      good = (n >= SPB - TOL) && (r <= TOL || r >= SPB - TOL);
      mid  = (m_ph == SPB / 2);
      m_bvalid = (mid && m_lock != 0) ? 1 : 0;
      if (m_bvalid != 0) begin
        m_bout = s;
        m_sout = int'(din);
      end
      if (m_lock == 0) begin
        if (e) begin
          if (good) begin
            m_gcnt++;
            if (m_gcnt == ACQ_EDGES) begin
              m_lock = 1;
              m_gcnt = 0;
            end
          end else m_gcnt = 0;
        end
      end else if (mid && m_run + 1 == MAX_RUN) begin
        m_lock = 0;
        m_gcnt = 0;
      end
      if (e) m_run = 0;
      else if (mid) m_run = (m_run < 255) ? m_run + 1 : 255;
      m_ph    = e ? 1 : (m_ph + 1) % SPB;
      m_ivl   = e ? 0 : ((m_ivl < 255) ? m_ivl + 1 : 255);
      m_sprev = s;
      m_acc   = m_acc + int'(din) - t;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("thr", int'(thr), m_acc >> AVG_SH);
      chk("locked", int'(locked), m_lock);
      chk("bvalid", int'(bvalid), m_bvalid);
      chk("bout", int'(bout), m_bout);
      chk("sout", int'(sout), m_sout);
      if (bvalid) begin
        bv_cnt++;
        chk("sout_level", int'(sout), bout ? 200 : 40);
      end
      if (mono_chk) begin
        chk("thr_monotonic", (int'(thr) >= prev_thr) ? 1 : 0, 1);
        chk("thr_bound", (int'(thr) <= 200) ? 1 : 0, 1);
      end
      if (lock_hold) chk("lock_hold", int'(locked), 1);
      prev_thr = int'(thr);
    end
  end

  task automatic smp(input int v, input bit gap);
    @(negedge clk);
    din = 8'(v);
    den = 1'b1;
    if (gap) begin
      @(negedge clk);
      den = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      den = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    den = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_thr"}, int'(thr), 128);
    chk({tag, "_locked"}, int'(locked), 0);
    chk({tag, "_bvalid"}, int'(bvalid), 0);
    chk({tag, "_sout"}, int'(sout), 0);
    chk({tag, "_bout"}, int'(bout), 0);
  endtask

  typedef struct { int v; int len; } seg_t;
  seg_t segs[10];

  initial begin
    int idx;
    rst = 1'b1;
    den = 1'b0;
    din = '0;
    @(negedge clk);
    chk_en = 1;

    // Reset held while den toggles
    repeat (4) begin
      @(negedge clk);
      den = ~den;
      din = 8'($urandom);
    end
    @(negedge clk);
    den = 1'b0;
    chk_reset_vals("rst_hold");
    rst = 1'b0;
    repeat (20) smp(128, 0);
    idle(3);
    chk("t1_no_bvalid", bv_cnt, 0);

    // Constant level: single bad edge, threshold creeps up
    mono_chk = 1;
    repeat (64) smp(200, 0);
    idle(3);
    mono_chk = 0;
    chk("t2_locked", int'(locked), 0);
    chk("t2_no_bvalid", bv_cnt, 0);
    chk("t2_thr_rose", (int'(thr) > 128) ? 1 : 0, 1);

    // Square wave, den every other clock: lock on the 5th transition
    do_reset();
    bv_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < 8; j++) begin
        smp((k % 2 != 0) ? 40 : 200, 1);
        if (k == 3 && j == 7) chk("t3_not_yet_locked", int'(locked), 0);
        if (k == 4 && j == 0) chk("t3_locked_5th_edge", int'(locked), 1);
      end
    end
    idle(3);
    chk("t3_bvalid_count", bv_cnt, 6);

    // Jittered bit lengths while locked: one strobe per bit
    bv_cnt = 0;
    lock_hold = 1;
    for (int b = 0; b < 20; b++) begin
      int len;
      len = int'($urandom_range(9, 7));
      repeat (len) smp((b % 2 != 0) ? 40 : 200, 0);
    end
    idle(3);
    lock_hold = 0;
    chk("t4_bvalid_count", bv_cnt, 20);
    chk("t4_locked", int'(locked), 1);

    // 17 bits without a transition: 16 strobes, then lock drops
    bv_cnt = 0;
    repeat (136) smp(200, 0);
    idle(3);
    chk("t6_bvalid_count", bv_cnt, 16);
    chk("t6_unlocked", int'(locked), 0);

    // Glitch after 3 good edges clears acquisition progress
    do_reset();
    segs = '{'{200, 8}, '{40, 8}, '{200, 8}, '{40, 4}, '{200, 3},
             '{40, 8}, '{200, 8}, '{40, 8}, '{200, 8}, '{40, 8}};
    idx = 0;
    foreach (segs[i]) begin
      repeat (segs[i].len) begin
        smp(segs[i].v, 1);
        if (idx == 39) chk("t5_no_lock_after_glitch", int'(locked), 0);
        if (idx == 62) chk("t5_not_yet_locked", int'(locked), 0);
        if (idx == 63) chk("t5_locked", int'(locked), 1);
        idx++;
      end
    end

    // Reset asserted while locked
    chk("t6_prelocked", int'(locked), 1);
    @(negedge clk);
    rst = 1'b1;
    den = 1'b1;
    din = 8'd200;
    @(negedge clk);
    chk_reset_vals("rst_midlock");
    rst = 1'b0;
    den = 1'b0;
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
